// File: rtl/ra1shd_ibm512x8_sram_pkg.sv
// Shared constants for the 512x8 single-port SRAM: geometry and enable encodings.
package ra1shd_ibm512x8_sram_pkg;
    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 9;
    localparam int RAM_DEPTH      = 512;

    localparam logic CEN_ACTIVE = 1'b0;
    localparam logic WEN_WRITE  = 1'b0;
endpackage

// File: rtl/ra1shd_array.sv
// Storage array: one synchronous write port, one asynchronous read port.
module ra1shd_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ra1shd_ibm512x8_sram.sv
// 512x8 synchronous single-port SRAM with registered read and write-through.
// Define RAM_CLEAR_EN to zero the whole array after every reset (BUSY high meanwhile).
module ra1shd_ibm512x8_sram
    import ra1shd_ibm512x8_sram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DEPTH      = RAM_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CEN,
    input  logic                  WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  BUSY
);
    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef RAM_CLEAR_EN
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] sweep_q;

    // Reset parks the counter at 0; one word is cleared per cycle once RST drops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q  <= 1'b1;
            sweep_q <= '0;
        end else if (busy_q) begin
            sweep_q <= sweep_q + ADDR_WIDTH'(1);
            if (sweep_q == ADDR_WIDTH'(DEPTH - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy       = busy_q;
    assign sweep_addr = sweep_q;
`else
    assign busy       = 1'b0;
    assign sweep_addr = '0;
`endif

    // Final else only fires on X enables in simulation and poisons the word.
    always_comb begin
        we    = 1'b0;
        waddr = A;
        wdata = D;
        if (RST) begin
            we = 1'b0;
        end else if (busy) begin
            we    = 1'b1;
            waddr = sweep_addr;
            wdata = '0;
        end else if (CEN == CEN_ACTIVE && WEN == WEN_WRITE) begin
            we = 1'b1;
        end else if (CEN != CEN_ACTIVE || WEN != WEN_WRITE) begin
            we = 1'b0;
        end else begin
            we    = 1'b1;
            wdata = 'x;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q <= '0;
        end else if (busy) begin
            q_q <= q_q;
        end else if (CEN == CEN_ACTIVE) begin
            if (WEN == WEN_WRITE) begin
                q_q <= D;
            end else if (WEN != WEN_WRITE) begin
                q_q <= rdata;
            end else begin
                q_q <= 'x;
            end
        end else if (CEN != CEN_ACTIVE) begin
            q_q <= q_q;
        end else begin
            q_q <= 'x;
        end
    end

    ra1shd_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk_i  (CLK),
        .we_i   (we),
        .waddr_i(waddr),
        .wdata_i(wdata),
        .raddr_i(A),
        .rdata_o(rdata)
    );

    assign Q    = q_q;
    assign BUSY = busy;
endmodule

// File: tb/tb_ra1shd_ibm512x8_sram.sv
// Directed bench for the 512x8 SRAM: word-level memory model plus literal spot checks.
module tb_ra1shd_ibm512x8_sram;
    logic       CLK = 1'b0;
    logic       RST;
    logic       CEN;
    logic       WEN;
    logic [8:0] A;
    logic [7:0] D;
    wire  [7:0] Q;
    wire        BUSY;

    int checks = 0;
    int errors = 0;

    // Behavioural model: memory contents, which words are defined, expected Q.
    logic [7:0] m_mem [512];
    bit         m_wr  [512];
    logic [7:0] m_q;
    bit         m_known = 1'b0;
    bit         m_sweep = 1'b0;

    ra1shd_ibm512x8_sram dut (
        .CLK (CLK),
        .RST (RST),
        .CEN (CEN),
        .WEN (WEN),
        .A   (A),
        .D   (D),
        .Q   (Q),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit cen, input bit wen,
                       input logic [8:0] a, input logic [7:0] d);
        RST = rst; CEN = cen; WEN = wen; A = a; D = d;
        @(posedge CLK);
        if (rst) begin
            m_q = 8'h00;
            m_known = 1'b1;
        end else if (!m_sweep && !cen) begin
            if (!wen) begin
                m_mem[a] = d;
                m_wr[a]  = 1'b1;
                m_q      = d;
                m_known  = 1'b1;
            end else begin
                m_q     = m_mem[a];
                m_known = m_wr[a];
            end
        end
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (m_known) chk("model_q", {8'h00, Q}, {8'h00, m_q});
`ifndef RAM_CLEAR_EN
        if (m_known) chk("busy_low", {15'h0, BUSY}, 16'h0);
`endif
    end

    initial begin
        logic [7:0] lo;
        logic [7:0] hi;
        for (int i = 0; i < 512; i++) m_wr[i] = 1'b0;
        RST = 1'b1; CEN = 1'b1; WEN = 1'b1; A = '0; D = '0;
        @(negedge CLK);
        cyc(1, 1, 1, 9'h000, 8'h00);
        cyc(1, 1, 1, 9'h000, 8'h00);
        chk("reset_q", {8'h00, Q}, 16'h0000);
`ifdef RAM_CLEAR_EN
        chk("reset_busy", {15'h0, BUSY}, 16'h0001);
        begin
            int n;
            n = 0;
            m_sweep = 1'b1;
            while (BUSY && n < 600) begin
                cyc(0, 0, 0, 9'h005, 8'h77);
                n++;
            end
            chk("sweep_len", 16'(n), 16'd512);
            m_sweep = 1'b0;
            for (int i = 0; i < 512; i++) begin
                m_mem[i] = 8'h00;
                m_wr[i]  = 1'b1;
            end
        end
        cyc(0, 0, 1, 9'h005, 8'h00);
        chk("sweep_ignored_wr", {8'h00, Q}, 16'h0000);
        cyc(0, 0, 1, 9'h000, 8'h00);
        chk("clear_0", {8'h00, Q}, 16'h0000);
        cyc(0, 0, 1, 9'h1FF, 8'h00);
        chk("clear_1ff", {8'h00, Q}, 16'h0000);
`else
        chk("reset_busy", {15'h0, BUSY}, 16'h0000);
`endif
        // Write then read
        cyc(0, 0, 0, 9'h000, 8'hAB);
        cyc(0, 0, 0, 9'h001, 8'h3C);
        cyc(0, 0, 1, 9'h000, 8'h00);
        chk("read_0", {8'h00, Q}, 16'h00AB);
        cyc(0, 0, 1, 9'h001, 8'h00);
        chk("read_1", {8'h00, Q}, 16'h003C);
        // Write-through
        cyc(0, 0, 0, 9'h1FF, 8'h5A);
        chk("wr_through", {8'h00, Q}, 16'h005A);
        cyc(0, 0, 1, 9'h1FF, 8'h00);
        chk("read_1ff", {8'h00, Q}, 16'h005A);
        // Chip disable
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 9'h1FF, 8'hFF);
            chk("cen_hold", {8'h00, Q}, 16'h005A);
        end
        cyc(0, 0, 1, 9'h1FF, 8'h00);
        chk("cen_no_write", {8'h00, Q}, 16'h005A);
        // Instruction pair, little-endian
        cyc(0, 0, 0, 9'd32, 8'h34);
        cyc(0, 0, 0, 9'd33, 8'h12);
        cyc(0, 0, 1, 9'd32, 8'h00);
        lo = Q;
        chk("instr_lo", {8'h00, lo}, 16'h0034);
        cyc(0, 0, 1, 9'd33, 8'h00);
        hi = Q;
        chk("instr_hi", {8'h00, hi}, 16'h0012);
        chk("instr_word", {hi, lo}, 16'h1234);
        // Scattered pattern, checked by the model on readback
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 9'(i * 61 + 7), 8'(i * 29 + 1));
        for (int i = 7; i >= 0; i--) cyc(0, 0, 1, 9'(i * 61 + 7), 8'h00);
        cyc(0, 0, 1, 9'd190, 8'h00);
        chk("pattern_190", {8'h00, Q}, 16'h0058);
`ifndef RAM_CLEAR_EN
        // Reset during a read; contents survive
        cyc(1, 0, 1, 9'h000, 8'h00);
        chk("rst_mid_q", {8'h00, Q}, 16'h0000);
        cyc(1, 0, 0, 9'h000, 8'h99);
        chk("rst_drops_wr_q", {8'h00, Q}, 16'h0000);
        cyc(0, 0, 1, 9'h000, 8'h00);
        chk("rst_keeps_mem", {8'h00, Q}, 16'h00AB);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
